// File: rtl/exp_pwl_pkg.sv
// Shared BF16 field layout, special constants and config FSM state type
// for the piecewise-linear exp() approximator.
package exp_pwl_pkg;

    localparam int BF16_S_POS = 15;
    localparam int BF16_E_MSB = 14;
    localparam int BF16_E_LSB = 7;
    localparam int BF16_E_W   = 8;
    localparam int BF16_M_W   = 7;
    localparam int BF16_BIAS  = 127;

    localparam logic [15:0] BF16_ONE  = 16'h3F80;
    localparam logic [15:0] BF16_PINF = 16'h7F80;
    localparam logic [15:0] BF16_ZERO = 16'h0000;

    // Table-write handshake: run traffic, drain the pipe, then accept writes.
    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_DRAIN = 2'd1,
        S_CFG   = 2'd2
    } cfg_state_t;

endpackage

// File: rtl/exp_pwl_lane.sv
// One BF16 lane of the exp() approximator: stage 2 (decode, table address,
// multiply) and stage 3 (add / saturate select). The table itself lives in
// the top; this lane presents the lookup address and receives the entry.
// Optional EXP_PWL_ROUND_EN: round-half-up of the 7 bits dropped from the
// slope product instead of truncating them.
module exp_pwl_lane
    import exp_pwl_pkg::*;
#(
    parameter int OFFSET_WIDTH = 8,
    parameter int EMIN         = -7,
    parameter int EMAX         = 6,
    parameter int IDXW         = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    adv,
    input  logic [15:0]             x,
    output logic                    lut_sgn,
    output logic [IDXW-1:0]         lut_idx,
    input  logic [15:0]             lut_base,
    input  logic [OFFSET_WIDTH-1:0] lut_offset,
    output logic [15:0]             y
);

    localparam int PW = BF16_M_W + OFFSET_WIDTH;
    localparam logic [8:0] E_LO = 9'(BF16_BIAS + EMIN);
    localparam logic [8:0] E_HI = 9'(BF16_BIAS + EMAX);

    logic [BF16_E_W-1:0] e;
    logic [BF16_M_W-1:0] m;
    logic [PW-1:0]       product;

    assign lut_sgn = x[BF16_S_POS];
    assign e       = x[BF16_E_MSB:BF16_E_LSB];
    assign m       = x[BF16_M_W-1:0];
    assign lut_idx = IDXW'({1'b0, e} - E_LO);
    assign product = PW'(m) * PW'(lut_offset);

    logic          p2_sgn;
    logic          p2_big;
    logic          p2_small;
    logic [15:0]   p2_base;
    logic [PW-1:0] p2_product;

    // Stage 2: capture product, table base and region flags.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is assigned with <= so every flop samples pre-edge values.
        if (!rst_n) begin
            p2_sgn     <= 1'b0;
            p2_big     <= 1'b0;
            p2_small   <= 1'b0;
            p2_base    <= '0;
            p2_product <= '0;
        end else if (adv) begin
            p2_sgn     <= lut_sgn;
            p2_big     <= ({1'b0, e} >= E_HI);
            p2_small   <= ({1'b0, e} < E_LO);
            p2_base    <= lut_base;
            p2_product <= product;
        end
    end

    logic [15:0] pu;
`ifdef EXP_PWL_ROUND_EN
    localparam int ROUND_HALF = 1 << (BF16_M_W - 1);
    logic [PW:0] rounded;
    // One spare bit so the +64 can never wrap the product.
    assign rounded = {1'b0, p2_product} + (PW + 1)'(ROUND_HALF);
    assign pu      = 16'(rounded >> BF16_M_W);
`else
    assign pu = 16'(p2_product >> BF16_M_W);
`endif

    logic [15:0] y_next;

    // Stage 3 select: saturation wins over the small region, else the PWL value.
    always_comb begin
        // NOTE: default assignment first keeps this block latch-free.
        y_next = p2_base + pu;
        if (p2_big) begin
            y_next = p2_sgn ? BF16_ZERO : BF16_PINF;
        end else if (p2_small) begin
            y_next = BF16_ONE;
        end
    end

    // Stage 3: register the lane result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y <= '0;
        end else if (adv) begin
            y <= y_next;
        end
    end

endmodule

// File: rtl/exp_pwl_bf16_pipe.sv
// Multi-lane 3-stage BF16 exp() approximator with a shared PWL table,
// valid/ready streaming and a config path that drains the pipe before
// any table write. Optional macro EXP_PWL_ROUND_EN selects round-half-up
// of the slope product (see exp_pwl_lane).
module exp_pwl_bf16_pipe
    import exp_pwl_pkg::*;
#(
    parameter int LANES        = 1,
    parameter int OFFSET_WIDTH = 8,
    parameter int EMIN         = -7,
    parameter int EMAX         = 6,
    localparam int SEGS        = EMAX - EMIN,
    localparam int IDXW        = (SEGS > 1) ? $clog2(SEGS) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [16*LANES-1:0]     in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [16*LANES-1:0]     out_data,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic                    cfg_sgn,
    input  logic [IDXW-1:0]         cfg_idx,
    input  logic [15:0]             cfg_base,
    input  logic [OFFSET_WIDTH-1:0] cfg_offset
);

    // Power-of-two depth so any lane address is in range; slots >= SEGS are
    // never written and stay zero.
    localparam int TBL = 1 << IDXW;

    cfg_state_t state;
    logic       live;
    logic       adv;
    logic       in_fire;
    logic       s1_valid;
    logic       s2_valid;
    logic       pipe_empty;
    logic [16*LANES-1:0] s1_data;

    logic [15:0]             bases   [2][TBL];
    logic [OFFSET_WIDTH-1:0] offsets [2][TBL];
    logic [15:0]             lane_y  [LANES];

    assign adv        = !out_valid || out_ready;
    assign in_ready   = live && (state == S_RUN) && !cfg_valid && adv;
    assign in_fire    = in_valid && in_ready;
    assign pipe_empty = !s1_valid && !s2_valid && !out_valid;

    // Config FSM; live keeps in_ready low while reset is applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_RUN;
            cfg_ready <= 1'b0;
            live      <= 1'b0;
        end else begin
            live <= 1'b1;
            case (state)
                S_RUN: begin
                    if (cfg_valid) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (!cfg_valid) begin
                        state <= S_RUN;
                    end else if (pipe_empty) begin
                        state     <= S_CFG;
                        cfg_ready <= 1'b1;
                    end
                end
                S_CFG: begin
                    if (!cfg_valid) begin
                        state     <= S_RUN;
                        cfg_ready <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_RUN;
                    cfg_ready <= 1'b0;
                end
            endcase
        end
    end

    // Segment table; out-of-range indices are acknowledged but not stored.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the table must read zero after reset, so it is built from
        // resettable flops rather than an inferred RAM.
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < TBL; i++) begin
                    bases[s][i]   <= '0;
                    offsets[s][i] <= '0;
                end
            end
        end else if (cfg_valid && cfg_ready && (int'(cfg_idx) < SEGS)) begin
            bases[cfg_sgn][cfg_idx]   <= cfg_base;
            offsets[cfg_sgn][cfg_idx] <= cfg_offset;
        end
    end

    // Stage 1 input register and the valid shift chain; all hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s2_valid  <= 1'b0;
            out_valid <= 1'b0;
            s1_data   <= '0;
        end else if (adv) begin
            s1_valid  <= in_fire;
            s2_valid  <= s1_valid;
            out_valid <= s2_valid;
            if (in_fire) s1_data <= in_data;
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic            lut_sgn;
        logic [IDXW-1:0] lut_idx;

        exp_pwl_lane #(
            .OFFSET_WIDTH (OFFSET_WIDTH),
            .EMIN         (EMIN),
            .EMAX         (EMAX),
            .IDXW         (IDXW)
        ) u_lane (
            .clk        (clk),
            .rst_n      (rst_n),
            .adv        (adv),
            .x          (s1_data[16*g +: 16]),
            .lut_sgn    (lut_sgn),
            .lut_idx    (lut_idx),
            .lut_base   (bases[lut_sgn][lut_idx]),
            .lut_offset (offsets[lut_sgn][lut_idx]),
            .y          (lane_y[g])
        );
    end

    // Pack the per-lane results onto the output bus.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < LANES; i++) begin
            out_data[16*i +: 16] = lane_y[i];
        end
    end

endmodule
